axi_lite_slave_regs: RTL

- AXI4-Lite slave register file; the downstream consumer of axi_lite_master transactions on the same axi_lite_if.
- Holds NUM_REGS 32-bit read/write registers, applies byte strobes, and returns SLVERR for out-of-range addresses.
- Exposes register contents and per-register write pulses to user logic.
- Supports one outstanding write and one outstanding read. AW and W are accepted independently, in either order.

---
 rtl/axi_lite_slave_regs_if.sv | 43 ++++
 rtl/axi_lite_slave_regs.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle shared by the register-file slave and its master.
// Latency: none, signal bundle only.
// Backpressure: plain valid/ready on all five channels.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // write address channel
  addr_t               awaddr;
  logic                awvalid;
  logic                awready;
  // write data channel
  data_t               wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  // write response channel
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // read address channel
  addr_t               araddr;
  logic                arvalid;
  logic                arready;
  // read data channel
  data_t               rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file: NUM_REGS x 32-bit registers with byte strobes and SLVERR decode.
// Latency: bvalid one cycle after the later of AW/W; rvalid one cycle after AR.
// Backpressure: one outstanding write and one read; ready drops while a response is pending.
module axi_lite_slave_regs #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_if.slave              s_axi_lite,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]    wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // word-address limit, sized to the word-address field so the compare is width-clean
  localparam logic [ADDR_W-3:0] REG_LIMIT = (ADDR_W-2)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // register storage
  logic [31:0] regs [NUM_REGS];

  // write-side capture state
  logic              aw_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic              w_held;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  // response state
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;

  // write-side combinational terms
  logic              awready_c;
  logic              wready_c;
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_in_range;
  logic [NUM_REGS-1:0] wr_sel;

  // read-side combinational terms
  logic              arready_c;
  logic              ar_hs;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;

  // byte offset bits never take part in decode
  logic              unused_addr_lsb;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2] < REG_LIMIT;
  endfunction

  // Readies depend only on held state, never on the incoming valids.
  assign awready_c = !aw_held && !bvalid_q;
  assign wready_c  = !w_held  && !bvalid_q;
  assign arready_c = !rvalid_q;

  assign aw_hs = s_axi_lite.awvalid && awready_c;
  assign w_hs  = s_axi_lite.wvalid  && wready_c;
  assign ar_hs = s_axi_lite.arvalid && arready_c;

  // A write commits once both halves exist, whether held or arriving this cycle.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? awaddr_q : s_axi_lite.awaddr;
  assign wr_data = w_held  ? wdata_q  : s_axi_lite.wdata;
  assign wr_strb = w_held  ? wstrb_q  : s_axi_lite.wstrb;

  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign wr_in_range = addr_in_range(wr_addr);

  assign rd_idx      = s_axi_lite.araddr[IDX_W+1:2];
  assign rd_in_range = addr_in_range(s_axi_lite.araddr);

  assign unused_addr_lsb = ^{wr_addr[1:0], s_axi_lite.araddr[1:0]};

  // Decode the committing write into a one-hot register select.
  always_comb begin
    wr_sel = '0;
    if (commit && wr_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_sel[i] = (wr_idx == IDX_W'(i));
      end
    end
  end

  // Hold whichever of AW/W arrives first until its partner shows up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held  <= 1'b0;
      awaddr_q <= '0;
      w_held   <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi_lite.awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_lite.wdata;
        wstrb_q <= s_axi_lite.wstrb;
      end
    end
  end

  // Raise the write response on commit and hold it until the master takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_lite.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Apply strobed byte writes to the selected register and pulse its write flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
              regs[i][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
      wr_pulse <= wr_sel;
    end
  end

  // Capture read data on the AR handshake; same-edge writes are seen next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (rd_in_range) begin
        rdata_q <= regs[rd_idx];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end else if (rvalid_q && s_axi_lite.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Flatten register contents for user logic.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[32*g +: 32] = regs[g];
  end

  assign s_axi_lite.awready = awready_c;
  assign s_axi_lite.wready  = wready_c;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.arready = arready_c;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rresp   = rresp_q;
  assign s_axi_lite.rdata   = rdata_q;

endmodule
